// File: rtl/rijndael_pkg.sv
// Shared Rijndael constants and index helpers for the round datapath.
// Byte k of a state is s[r][c] with k = 4*c + r (column-major order).
package rijndael_pkg;

    localparam int unsigned NB_128 = 4;
    localparam int unsigned NB_192 = 6;
    localparam int unsigned NB_256 = 8;

    // ShiftRows offset Cr for row r; only the 256-bit block widens rows 2 and 3.
    function automatic int unsigned row_offset(input int unsigned nb, input int unsigned r);
        if (r == 0) begin
            return 0;
        end
        if (r == 1) begin
            return 1;
        end
        if (nb == NB_256) begin
            return r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned byte_idx(input int unsigned r, input int unsigned c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_core.sv
// Combinational ShiftRows / InvShiftRows for Nb = 4, 6 or 8 columns.
// Pure wiring plus one 2:1 byte mux per output byte.
module shift_rows_core
    import rijndael_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [32*NB-1:0] state,
    input  logic             inv,
    output logic [32*NB-1:0] state_out
);

    localparam int unsigned W = 32 * NB;

    if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
        $error("shift_rows_core: NB must be 4, 6 or 8");
    end

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned CR      = row_offset(NB, r);
            localparam int unsigned DST     = byte_idx(r, c);
            localparam int unsigned SRC_FWD = byte_idx(r, (c + CR) % NB);
            localparam int unsigned SRC_INV = byte_idx(r, (c + NB - CR) % NB);

            assign state_out[W-1-8*DST -: 8] = inv ? state[W-1-8*SRC_INV -: 8]
                                                   : state[W-1-8*SRC_FWD -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// Streaming ShiftRows unit: permutes each accepted state at enqueue and buffers it,
// with its tag, in a DEPTH-entry FIFO driven straight from storage.
module shift_rows_stream
    import rijndael_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [32*NB-1:0]           in_state,
    input  logic                       in_inv,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [32*NB-1:0]           out_state,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned W     = 32 * NB;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("shift_rows_stream: DEPTH must be at least 1");
    end

    logic [W-1:0]     r_state [DEPTH];
    logic [TAG_W-1:0] r_tag   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [W-1:0] w_state_perm;
    logic         w_push;
    logic         w_pop;

    shift_rows_core #(
        .NB(NB)
    ) u_core (
        .state    (in_state),
        .inv      (in_inv),
        .state_out(w_state_perm)
    );

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = (r_count < CNT_W'(DEPTH)) && !rst;
    assign out_valid = (r_count != '0) && !rst;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign out_state = r_state[r_head];
    assign out_tag   = r_tag[r_head];
    assign occupancy = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_state[r_tail] <= w_state_perm;
            r_tag[r_tail]   <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Directed bench: NB=4 / DEPTH=2 instance for flow and vectors, NB=8 instance for wide offsets.
module tb_shift_rows_stream;

    logic         clk;
    logic         rst;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_inv;
    logic [3:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_tag;
    logic [1:0]   occupancy;

    logic         b_in_valid;
    logic         b_in_ready;
    logic [255:0] b_in_state;
    logic         b_in_inv;
    logic [3:0]   b_in_tag;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [255:0] b_out_state;
    logic [3:0]   b_out_tag;
    logic [1:0]   b_occupancy;

    int checks = 0;
    int errors = 0;

    shift_rows_stream #(.NB(4), .DEPTH(2), .TAG_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_state (in_state),
        .in_inv   (in_inv),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_state(out_state),
        .out_tag  (out_tag),
        .occupancy(occupancy)
    );

    shift_rows_stream #(.NB(8), .DEPTH(2), .TAG_W(4)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_state (b_in_state),
        .in_inv   (b_in_inv),
        .in_tag   (b_in_tag),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_state(b_out_state),
        .out_tag  (b_out_tag),
        .occupancy(b_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference for Nb=4: offsets are simply Cr = r.
    function automatic logic [127:0] model4(input logic [127:0] s, input logic inv);
        logic [7:0]   b [4][4];
        logic [127:0] res;
        int           src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = s[127-8*(4*c+r) -: 8];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                res[127-8*(4*c+r) -: 8] = b[r][src];
            end
        return res;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (occupancy !== 2'd0) begin
            errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready);
        end
    endtask

    // Push one state with out_ready low, check it one cycle later, then pop it.
    task automatic test_vector(input string name, input logic [127:0] s, input logic inv,
                               input logic [3:0] tag, input logic [127:0] exp);
        @(negedge clk);
        in_valid = 1'b1; in_state = s; in_inv = inv; in_tag = tag;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_in_ready got %b want 1", name, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || occupancy !== 2'd1) begin
            errors++;
            $display("FAIL %s_latency got valid=%b occ=%0d want valid=1 occ=1",
                     name, out_valid, occupancy);
        end
        checks++;
        if (out_state !== exp) begin
            errors++; $display("FAIL %s_state got %h want %h", name, out_state, exp);
        end
        checks++;
        if (out_tag !== tag) begin
            errors++; $display("FAIL %s_tag got %h want %h", name, out_tag, tag);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_pop got valid=%b want 0", name, out_valid);
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] s;
        logic [127:0] f;
        for (int i = 0; i < 9; i++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            in_valid = 1'b1; in_state = s; in_inv = 1'b0; in_tag = 4'(i);
            @(negedge clk);
            in_valid = 1'b0;
            f = out_state;
            checks++;
            if (f !== model4(s, 1'b0)) begin
                errors++; $display("FAIL roundtrip_fwd got %h want %h", f, model4(s, 1'b0));
            end
            out_ready = 1'b1;
            in_valid = 1'b1; in_state = f; in_inv = 1'b1; in_tag = 4'(i + 1);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_state !== s || out_tag !== 4'(i + 1) || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL roundtrip_inv got %h tag %h occ %0d want %h tag %h occ 1",
                         out_state, out_tag, occupancy, s, 4'(i + 1));
            end
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_nb8();
        logic [255:0] exp;
        exp = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
        @(negedge clk);
        for (int k = 0; k < 32; k++) b_in_state[255-8*k -: 8] = 8'(k);
        b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_tag = 4'hc;
        @(negedge clk);
        b_in_valid = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_state !== exp || b_out_tag !== 4'hc) begin
            errors++;
            $display("FAIL nb8_fwd got v=%b %h tag %h want v=1 %h tag c",
                     b_out_valid, b_out_state, b_out_tag, exp);
        end
        b_in_valid = 1'b1; b_in_state = exp; b_in_inv = 1'b1; b_in_tag = 4'h3;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        checks++;
        for (int k = 0; k < 32; k++) exp[255-8*k -: 8] = 8'(k);
        if (b_out_state !== exp || b_out_tag !== 4'h3) begin
            errors++;
            $display("FAIL nb8_inv got %h tag %h want %h tag 3", b_out_state, b_out_tag, exp);
        end
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] sa, sb, sc;
        sa = 128'h00112233445566778899aabbccddeeff;
        sb = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        sc = 128'hdeadbeef0123456789abcdeffedcba98;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_state = sa; in_inv = 1'b0; in_tag = 4'h1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second_ready got %b want 1", in_ready);
        end
        in_state = sb; in_inv = 1'b1; in_tag = 4'h2;
        @(negedge clk);
        in_state = sc; in_inv = 1'b0; in_tag = 4'h3;
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            errors++;
            $display("FAIL bp_full got ready=%b occ=%0d want ready=0 occ=2", in_ready, occupancy);
        end
        checks++;
        if (out_tag !== 4'h1 || out_state !== model4(sa, 1'b0)) begin
            errors++; $display("FAIL bp_head_a got tag %h %h", out_tag, out_state);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_pop got occ=%0d ready=%b want occ=1 ready=1",
                     occupancy, in_ready);
        end
        checks++;
        if (out_tag !== 4'h2 || out_state !== model4(sb, 1'b1)) begin
            errors++; $display("FAIL bp_head_b got tag %h %h", out_tag, out_state);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd2 || out_tag !== 4'h2) begin
            errors++;
            $display("FAIL bp_c_accept got occ=%0d tag %h want occ=2 tag 2", occupancy, out_tag);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_tag !== 4'h3 || out_state !== model4(sc, 1'b0)) begin
            errors++; $display("FAIL bp_head_c got tag %h %h", out_tag, out_state);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL bp_drain got v=%b occ=%0d", out_valid, occupancy);
        end
    endtask

    task automatic test_streaming();
        logic [127:0] s [16];
        for (int i = 0; i < 16; i++) s[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 4'(i - 1) ||
                    out_state !== model4(s[i-1], 1'((i - 1) % 2)) || occupancy > 2'd1) begin
                    errors++;
                    $display("FAIL stream_%0d got v=%b tag %h occ %0d %h want %h", i - 1,
                             out_valid, out_tag, occupancy, out_state,
                             model4(s[i-1], 1'((i - 1) % 2)));
                end
            end
            if (i < 16) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL stream_ready_%0d got %b want 1", i, in_ready);
                end
                in_valid = 1'b1; in_state = s[i]; in_inv = 1'(i % 2); in_tag = 4'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_end got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] sx;
        sx = 128'h102132435465768798a9bacbdcedfe0f;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_state = 128'h1; in_inv = 1'b0; in_tag = 4'h7;
        @(negedge clk);
        in_tag = 4'h8;
        @(negedge clk);
        checks++;
        if (occupancy !== 2'd2) begin
            errors++; $display("FAIL mr_fill got occ=%0d want 2", occupancy);
        end
        rst = 1'b1;
        in_state = sx; in_inv = 1'b1; in_tag = 4'h9;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mr_cleared got v=%b occ=%0d ready=%b want 0/0/0",
                     out_valid, occupancy, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (occupancy !== 2'd1 || out_tag !== 4'h9 || out_state !== model4(sx, 1'b1)) begin
            errors++;
            $display("FAIL mr_first got occ=%0d tag %h %h want occ=1 tag 9 %h",
                     occupancy, out_tag, out_state, model4(sx, 1'b1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mr_alone got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_state = '0; in_inv = 1'b0; in_tag = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_state = '0; b_in_inv = 1'b0; b_in_tag = '0;
        b_out_ready = 1'b0;
        test_reset();
        test_vector("inv4", 128'h09287f476f746abf2c4a6204da08e3ee, 1'b1, 4'h5,
                    128'h090862bf6f28e3042c747feeda4a6a47);
        test_vector("fwd4", 128'h090862bf6f28e3042c747feeda4a6a47, 1'b0, 4'ha,
                    128'h09287f476f746abf2c4a6204da08e3ee);
        test_roundtrip();
        test_nb8();
        test_backpressure();
        test_streaming();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
